// File: rtl/mem_stage_if.sv
// Data-memory bus between mem_stage (master) and a variable-latency data memory (slave).
interface mem_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_ack, mem_rdata);
    modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_ack, mem_rdata);
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: req/ack transaction with data memory, stalls upstream while busy.
// Optional abort of stuck accesses via macro MEM_TIMEOUT_EN (sticky error flag).
module mem_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic [DATA_WIDTH-1:0] store_data,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [4:0]            rd_in,
    input  logic                  wb_enable_in,
    mem_stage_if.master           mem,
    output logic                  stall,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] result_out,
    output logic [4:0]            rd_out,
    output logic                  wb_enable_out,
    output logic                  error
);
    typedef enum logic {IDLE, ACCESS} state_e;

    state_e                state_q, state_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [4:0]            prd_q, prd_d;
    logic                  pwb_q, pwb_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [4:0]            rd_q, rd_d;
    logic                  wb_q, wb_d;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`endif

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        prd_d    = prd_q;
        pwb_d    = pwb_q;
        valid_d  = 1'b0;
        result_d = result_q;
        rd_d     = rd_q;
        wb_d     = wb_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    if (mem_read || mem_write) begin
                        // read+write together is a store: mem_write alone decides direction
                        we_d    = mem_write;
                        addr_d  = alu_result[ADDR_WIDTH-1:0];
                        wdata_d = store_data;
                        prd_d   = rd_in;
                        pwb_d   = wb_enable_in;
                        state_d = ACCESS;
`ifdef MEM_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        result_d = alu_result;
                        rd_d     = rd_in;
                        wb_d     = wb_enable_in;
                        valid_d  = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (mem.mem_ack) begin
                    result_d = we_q ? DATA_WIDTH'(addr_q) : mem.mem_rdata;
                    rd_d     = prd_q;
                    wb_d     = pwb_q;
                    valid_d  = 1'b1;
                    state_d  = IDLE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    // aborted access still retires, but must not write back
                    result_d = '0;
                    rd_d     = prd_q;
                    wb_d     = 1'b0;
                    valid_d  = 1'b1;
                    err_d    = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            prd_q    <= '0;
            pwb_q    <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
            rd_q     <= '0;
            wb_q     <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            prd_q    <= prd_d;
            pwb_q    <= pwb_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            rd_q     <= rd_d;
            wb_q     <= wb_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`endif
        end
    end

    // request is exactly "in ACCESS", so reset or completion drops it at the same edge
    assign mem.mem_req   = (state_q == ACCESS);
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

    assign stall = ((state_q == IDLE) && valid_in && (mem_read || mem_write)) ||
                   ((state_q == ACCESS) && !mem.mem_ack);

    assign valid_out     = valid_q;
    assign result_out    = result_q;
    assign rd_out        = rd_q;
    assign wb_enable_out = wb_q;
`ifdef MEM_TIMEOUT_EN
    assign error = err_q;
`else
    assign error = 1'b0;
`endif
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table, directed corner cases, random transactions vs. model.
module tb_mem_stage;
    localparam int DW = 32;
    localparam int AW = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          valid_in, mem_read, mem_write, wb_enable_in;
    logic [DW-1:0] alu_result, store_data;
    logic [4:0]    rd_in;
    logic          stall, valid_out, wb_enable_out, error;
    logic [DW-1:0] result_out;
    logic [4:0]    rd_out;

    always #5 clock = ~clock;

    mem_stage_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mif ();

    mem_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(4)) dut (
        .clock(clock), .reset(reset), .valid_in(valid_in), .alu_result(alu_result),
        .store_data(store_data), .mem_read(mem_read), .mem_write(mem_write), .rd_in(rd_in),
        .wb_enable_in(wb_enable_in), .mem(mif.master), .stall(stall), .valid_out(valid_out),
        .result_out(result_out), .rd_out(rd_out), .wb_enable_out(wb_enable_out), .error(error)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        vi;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        wb;
        logic        ev;
        logic [31:0] eres;
        logic [4:0]  erd;
        logic        ewb;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drive(input logic vi, input logic rd, input logic wr, input logic [31:0] alu,
                         input logic [31:0] sd, input logic [4:0] r, input logic wb);
        valid_in = vi; mem_read = rd; mem_write = wr; alu_result = alu;
        store_data = sd; rd_in = r; wb_enable_in = wb;
    endtask

    task automatic chk_wb(input string nm, input logic v, input logic [31:0] res,
                          input logic [4:0] r, input logic wb);
        chk({nm, ".valid_out"}, valid_out, v);
        chk({nm, ".result_out"}, result_out, res);
        chk({nm, ".rd_out"}, rd_out, r);
        chk({nm, ".wb_enable_out"}, wb_enable_out, wb);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, ".mem_req"}, mif.mem_req, 0);
        chk({nm, ".mem_we"}, mif.mem_we, 0);
        chk({nm, ".mem_addr"}, mif.mem_addr, 0);
        chk({nm, ".mem_wdata"}, mif.mem_wdata, 0);
        chk({nm, ".error"}, error, 0);
        chk_wb(nm, 0, 0, 0, 0);
    endtask

    // One random transaction; expected outputs derived from the instruction's meaning.
    task automatic rand_txn(input int idx);
        logic        is_rd, is_wr, vi, wb, is_mem;
        logic [31:0] alu, sd, rdata, exp_res;
        logic [4:0]  r;
        int          lat;
        string       nm;
        nm    = $sformatf("rand%0d", idx);
        vi    = ($urandom_range(0, 5) != 0);
        is_rd = $urandom_range(0, 1) == 1;
        is_wr = $urandom_range(0, 2) == 0;
        alu   = $urandom; sd = $urandom; rdata = $urandom;
        r     = 5'($urandom); wb = $urandom_range(0, 1) == 1;
        is_mem = vi && (is_rd || is_wr);
        drive(vi, is_rd, is_wr, alu, sd, r, wb);
        #1 chk({nm, ".stall_accept"}, stall, is_mem);
        step();
        if (!vi) begin
            chk({nm, ".idle_valid"}, valid_out, 0);
            return;
        end
        if (!is_mem) begin
            chk_wb({nm, ".alu"}, 1, alu, r, wb);
            return;
        end
        exp_res = is_wr ? alu : rdata;
        lat = $urandom_range(1, 4);
        for (int i = 1; i <= lat; i++) begin
            // garbage on the inputs must not disturb the access
            drive($urandom_range(0, 1) == 1, 1'b1, 1'b1, $urandom, $urandom, 5'($urandom), 1'b1);
            chk({nm, ".req"}, mif.mem_req, 1);
            chk({nm, ".addr"}, mif.mem_addr, alu);
            chk({nm, ".we"}, mif.mem_we, is_wr);
            if (is_wr) chk({nm, ".wdata"}, mif.mem_wdata, sd);
            chk({nm, ".no_valid"}, valid_out, 0);
            if (i == lat) begin
                mif.mem_ack = 1'b1; mif.mem_rdata = rdata;
            end
            #1 chk({nm, ".stall_access"}, stall, (i != lat));
            step();
        end
        mif.mem_ack = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        chk_wb({nm, ".mem"}, 1, exp_res, r, wb);
        chk({nm, ".req_drop"}, mif.mem_req, 0);
    endtask

    initial begin
        int cnt;
        drive(0, 0, 0, 0, 0, 0, 0);
        mif.mem_ack = 1'b0; mif.mem_rdata = '0;

        tbl[0] = '{1'b1, 32'h7,        5'd3,  1'b1, 1'b1, 32'h7,        5'd3,  1'b1};
        tbl[1] = '{1'b0, 32'h1234,     5'd9,  1'b0, 1'b0, 32'h7,        5'd3,  1'b1};
        tbl[2] = '{1'b1, 32'hFFFF_FFFF, 5'd31, 1'b0, 1'b1, 32'hFFFF_FFFF, 5'd31, 1'b0};
        tbl[3] = '{1'b1, 32'h0,        5'd0,  1'b1, 1'b1, 32'h0,        5'd0,  1'b1};
        tbl[4] = '{1'b1, 32'hA5A5_0001, 5'd17, 1'b1, 1'b1, 32'hA5A5_0001, 5'd17, 1'b1};
        tbl[5] = '{1'b0, 32'h5555,     5'd1,  1'b0, 1'b0, 32'hA5A5_0001, 5'd17, 1'b1};

        // reset state
        step(); step();
        chk_all_zero("reset");
        chk("reset.stall", stall, 0);
        reset = 1'b1;

        // ALU pass-through vectors
        foreach (tbl[i]) begin
            drive(tbl[i].vi, 0, 0, tbl[i].alu, 32'hFFFF, tbl[i].rd, tbl[i].wb);
            #1 chk($sformatf("vec%0d.stall", i), stall, 0);
            step();
            chk_wb($sformatf("vec%0d", i), tbl[i].ev, tbl[i].eres, tbl[i].erd, tbl[i].ewb);
        end

        // load, ack on the third request cycle
        drive(1, 1, 0, 32'h40, 32'h0, 5'd5, 1);
        #1 chk("load.stall_accept", stall, 1);
        step();
        drive(1, 0, 1, 32'h99, 32'h77, 5'd8, 0);
        for (int i = 0; i < 3; i++) begin
            chk("load.req", mif.mem_req, 1);
            chk("load.addr", mif.mem_addr, 32'h40);
            chk("load.we", mif.mem_we, 0);
            chk("load.valid_early", valid_out, 0);
            if (i == 2) begin
                mif.mem_ack = 1'b1; mif.mem_rdata = 32'hDEAD_BEEF;
            end
            #1 chk("load.stall", stall, (i != 2));
            step();
        end
        mif.mem_ack = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        chk_wb("load.retire", 1, 32'hDEAD_BEEF, 5'd5, 1);
        step();
        chk("load.single_pulse", valid_out, 0);

        // store with same-cycle ack, then ALU back-to-back
        drive(1, 1, 1, 32'h10, 32'h55, 5'd2, 0);
        step();
        chk("store.we", mif.mem_we, 1);
        chk("store.wdata", mif.mem_wdata, 32'h55);
        chk("store.addr", mif.mem_addr, 32'h10);
        mif.mem_ack = 1'b1; mif.mem_rdata = 32'hBAD0_BAD0;
        #1 chk("store.stall_ack", stall, 0);
        step();
        mif.mem_ack = 1'b0;
        drive(1, 0, 0, 32'h9, 32'h0, 5'd4, 1);
        chk_wb("store.retire", 1, 32'h10, 5'd2, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk_wb("b2b.alu", 1, 32'h9, 5'd4, 1);
        step();
        chk("b2b.end", valid_out, 0);

        // reset in the middle of an access, then a stray ack
        drive(1, 0, 1, 32'h24, 32'hAA, 5'd6, 1);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("rst_mid.req", mif.mem_req, 1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk_all_zero("rst_mid");
        mif.mem_ack = 1'b1; mif.mem_rdata = 32'h1111_2222;
        step();
        mif.mem_ack = 1'b0;
        chk("stray_ack.valid", valid_out, 0);
        chk("stray_ack.req", mif.mem_req, 0);
        chk("stray_ack.result", result_out, 0);

`ifdef MEM_TIMEOUT_EN
        // timeout with TIMEOUT_CYCLES = 4
        drive(1, 1, 0, 32'h80, 32'h0, 5'd7, 1);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (!mif.mem_req) break;
            cnt++;
            step();
        end
        chk("timeout.req_cycles", cnt, 4);
        chk_wb("timeout.retire", 1, 32'h0, 5'd7, 0);
        chk("timeout.error", error, 1);
        step(); step();
        chk("timeout.error_sticky", error, 1);
        chk("timeout.single_pulse", valid_out, 0);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("timeout.error_clear", error, 0);
`else
        cnt = 0;
        drive(1, 1, 0, 32'h80, 32'h0, 5'd7, 1);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            if (mif.mem_req) cnt++;
            step();
        end
        chk("no_timeout.req_held", cnt, 20);
        chk("no_timeout.error", error, 0);
        mif.mem_ack = 1'b1; mif.mem_rdata = 32'h0BAD_F00D;
        step();
        mif.mem_ack = 1'b0;
        chk_wb("no_timeout.retire", 1, 32'h0BAD_F00D, 5'd7, 1);
`endif

        for (int t = 0; t < 60; t++) rand_txn(t);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage that sits directly after `ex_stage` and consumes its `result` output as a data-memory address or pass-through value. The stage runs a request/acknowledge transaction with an external data memory of variable latency for loads and stores. It stalls the upstream stages while a transaction is outstanding. It presents one registered, validated result per instruction to write-back.

## Interface
- `DATA_WIDTH`, 32, width of data paths
- `ADDR_WIDTH`, 32, width of `mem_addr`; driven from `alu_result[ADDR_WIDTH-1:0]`
- `TIMEOUT_CYCLES`, 16, maximum cycles spent in ACCESS; used only with `MEM_TIMEOUT_EN`

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-low reset
- `valid_in`  in  1  an instruction is present on the inputs
- `alu_result`  in  DATA_WIDTH  `ex_stage` result; used as address or pass-through value
- `store_data`  in  DATA_WIDTH  store operand
- `mem_read`  in  1  load instruction
- `mem_write`  in  1  store instruction
- `rd_in`  in  5  destination register
- `wb_enable_in`  in  1  write-back enable
- `mem_req`  out  1  memory request; held until acknowledged
- `mem_we`  out  1  1 = write, 0 = read
- `mem_addr`  out  ADDR_WIDTH  access address
- `mem_wdata`  out  DATA_WIDTH  write data
- `mem_ack`  in  1  memory completion; qualifies `mem_rdata`
- `mem_rdata`  in  DATA_WIDTH  read data
- `stall`  out  1  combinational; upstream holds its outputs while this is 1
- `valid_out`  out  1  one-cycle pulse per retired instruction
- `result_out`  out  DATA_WIDTH  load data or pass-through value
- `rd_out`  out  5  registered `rd_in`
- `wb_enable_out`  out  1  registered `wb_enable_in`
- `error`  out  1  sticky timeout flag

## Operation
- FSM states: IDLE and ACCESS.
- **IDLE, `valid_in` = 1, no memory operation:**
  - `result_out` <= `alu_result`; `rd_out` and `wb_enable_out` are registered from the inputs.
  - `valid_out` = 1 on the next cycle.
  - The FSM stays in IDLE.
- **IDLE, `valid_in` = 1 with `mem_read` or `mem_write`:**
  - Latch the address, `store_data`, `rd_in` and `wb_enable_in`.
  - `mem_we` = `mem_write`.
  - Go to ACCESS.
- **`mem_read` and `mem_write` both high:** treat as a store; the read is ignored.
- **ACCESS:**
  - `mem_req` = 1; `mem_addr`, `mem_wdata` and `mem_we` are held stable.
  - Input ports are ignored.
  - On `mem_ack`, a load sets `result_out` <= `mem_rdata`; a store sets `result_out` <= address.
  - On `mem_ack`, `valid_out` = 1 on the next cycle and the FSM returns to IDLE.
- `stall` = (IDLE & `valid_in` & (`mem_read` | `mem_write`)) | (ACCESS & !`mem_ack`).
- `valid_in` = 0 in IDLE: `valid_out` = 0 on the next cycle; `result_out`, `rd_out` and `wb_enable_out` hold their values.
- `mem_ack` while in IDLE is ignored.

## Timing
- Reset (`reset` = 0 at an edge):
  - State goes to IDLE.
  - `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `valid_out`, `result_out`, `rd_out`, `wb_enable_out` and `error` all go to 0.
  - The timeout counter goes to 0.
- Reset during ACCESS: `mem_req` drops at that edge and the transaction is abandoned. A later stray `mem_ack` is ignored.
- Non-memory instruction: 1-cycle latency, accepted at edge N, `valid_out` high in cycle N+1.
- Memory instruction:
  - Accepted at edge N; `mem_req` is high from cycle N+1.
  - If `mem_ack` arrives in cycle N+k, `valid_out` is high in cycle N+k+1.
  - Minimum latency is 2 cycles (k = 1).
- Back-to-back: `stall` falls in the `mem_ack` cycle, so the next instruction is accepted in the following IDLE cycle with no bubble.
- `mem_req` never drops without `mem_ack`, reset, or a timeout.

## Configuration
- Macro `MEM_TIMEOUT_EN` defined:
  - A counter increments every cycle spent in ACCESS.
  - When it reaches `TIMEOUT_CYCLES` without `mem_ack`, the transaction is aborted: `mem_req` drops and the FSM returns to IDLE.
  - The aborted instruction still retires: `valid_out` pulses with `result_out` = 0 and `wb_enable_out` = 0.
  - `error` is set and remains 1 until reset.
  - The counter clears on every entry to ACCESS.
- Macro `MEM_TIMEOUT_EN` undefined: ACCESS waits indefinitely, no counter is built, and `error` is tied to 0.

## Test plan
- ALU pass-through: `valid_in` = 1, `alu_result` = 0x0000_0007, `rd_in` = 3, no memory operation -> next cycle `valid_out` = 1, `result_out` = 7, `rd_out` = 3; `stall` never asserts.
- Load with 3-cycle latency: `mem_read`, `alu_result` = 0x40, memory acks 3 cycles after `mem_req` with `mem_rdata` = 0xDEAD_BEEF -> `mem_addr` = 0x40 and `mem_we` = 0 held throughout; `stall` high until the ack cycle; `result_out` = 0xDEAD_BEEF with a single `valid_out` pulse.
- Store, then an ALU instruction back-to-back: `mem_write`, address 0x10, `store_data` = 0x55, same-cycle ack, then an ALU value of 9 -> `mem_we` = 1, `mem_wdata` = 0x55; two `valid_out` pulses on consecutive cycles with results 0x10 then 9.
- Reset mid-access: drive `reset` = 0 for one edge during ACCESS, then pulse `mem_ack` -> all outputs 0, FSM in IDLE, and no `valid_out` from the stray ack.
- Timeout (`MEM_TIMEOUT_EN` defined, `TIMEOUT_CYCLES` = 4, `mem_ack` never asserted):
  - `mem_req` drops after 4 ACCESS cycles.
  - `valid_out` pulses with `wb_enable_out` = 0 and `result_out` = 0.
  - `error` = 1 and stays set until reset.
